ym2149_bus_master: RTL

//  Host-side initiator for the YM2149/AY-3-8910 BDIR/BC parallel bus. Accepts register

---
 rtl/ym2149_bus_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ym2149_bus_master.sv
// Host-side YM2149/AY-3-8910 bus initiator: request FIFO plus ADDR/GAP/data/GAP sequencer.
// Optional feature: define YM_ADDR_CACHE_EN to skip ADDR/GAP1 when the register address is unchanged.
module ym2149_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASE_LEN  = 2,
  parameter int GAP_LEN    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       reqValid_i,
  output logic       reqReady_o,
  input  logic       reqWr_i,
  input  logic [3:0] reqAddr_i,
  input  logic [7:0] reqData_i,
  output logic       rspValid_o,
  output logic [7:0] rspData_o,
  output logic       busy_o,
  output logic       psgBdir_o,
  output logic       psgBc_o,
  output logic [7:0] psgDo_o,
  input  logic [7:0] psgDi_i
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] PHASE_LOAD = 4'(PHASE_LEN - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_LEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_GAP1 = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_GAP2 = 3'd5;

  // FIFO entry layout: [12] write flag, [11:8] register number, [7:0] write data
  logic [12:0]   fifoMem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          push, pop, start, fifoEmpty, cacheHit, phaseDone;
  logic [12:0]   fifoHead;

  logic [2:0]  state_q, state_d;
  logic [3:0]  phaseCnt_q, phaseCnt_d;
  logic [12:0] curReq_q, curReq_d;
  logic        rspValid_q, rspValid_d;
  logic [7:0]  rspData_q, rspData_d;

  assign reqReady_o = (count_q != FULL_COUNT);
  assign push       = reqValid_i && reqReady_o;
  assign fifoEmpty  = (count_q == '0);
  assign fifoHead   = fifoMem_q[rdPtr_q];
  assign phaseDone  = (phaseCnt_q == 4'd0);

  always_ff @(posedge clk_i) begin
    if (push) fifoMem_q[wrPtr_q] <= {reqWr_i, reqAddr_i, reqData_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef YM_ADDR_CACHE_EN
  logic       cacheValid_q;
  logic [3:0] cacheAddr_q;

  assign cacheHit = cacheValid_q && (cacheAddr_q == fifoHead[11:8]);

  // The cache tracks whatever address the PSG last latched through an ADDR phase
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cacheValid_q <= 1'b0;
      cacheAddr_q  <= 4'h0;
    end else if (start && !cacheHit) begin
      cacheValid_q <= 1'b1;
      cacheAddr_q  <= fifoHead[11:8];
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    phaseCnt_d = phaseDone ? phaseCnt_q : phaseCnt_q - 4'd1;
    curReq_d   = curReq_q;
    rspValid_d = 1'b0;
    rspData_d  = rspData_q;
    start      = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: start = !fifoEmpty;
      S_ADDR: if (phaseDone) begin
        state_d    = S_GAP1;
        phaseCnt_d = GAP_LOAD;
      end
      S_GAP1: if (phaseDone) begin
        state_d    = curReq_q[12] ? S_WR : S_RD;
        phaseCnt_d = PHASE_LOAD;
      end
      S_WR: if (phaseDone) begin
        state_d    = S_GAP2;
        phaseCnt_d = GAP_LOAD;
      end
      S_RD: if (phaseDone) begin
        state_d    = S_GAP2;
        phaseCnt_d = GAP_LOAD;
        rspValid_d = 1'b1;
        rspData_d  = psgDi_i;
      end
      S_GAP2: if (phaseDone) begin
        if (fifoEmpty) state_d = S_IDLE;
        else           start   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Starting a request overrides the per-state next values above
    if (start) begin
      pop        = 1'b1;
      curReq_d   = fifoHead;
      phaseCnt_d = PHASE_LOAD;
      state_d    = cacheHit ? (fifoHead[12] ? S_WR : S_RD) : S_ADDR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      phaseCnt_q <= 4'd0;
      curReq_q   <= 13'd0;
      rspValid_q <= 1'b0;
      rspData_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      phaseCnt_q <= phaseCnt_d;
      curReq_q   <= curReq_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
    end
  end

  always_comb begin
    psgBdir_o = 1'b0;
    psgBc_o   = 1'b0;
    psgDo_o   = 8'h00;
    case (state_q)
      S_ADDR: begin
        psgBdir_o = 1'b1;
        psgBc_o   = 1'b1;
        psgDo_o   = {4'h0, curReq_q[11:8]};
      end
      S_WR: begin
        psgBdir_o = 1'b1;
        psgDo_o   = curReq_q[7:0];
      end
      S_RD:    psgBc_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o     = !fifoEmpty || (state_q != S_IDLE);
  assign rspValid_o = rspValid_q;
  assign rspData_o  = rspData_q;

endmodule
